// File: rtl/vga_pkg.sv
// Shared types and default sizes for the VGA pixel-group fetch block.
package vga_pkg;

    localparam int unsigned MEM_AW_DEF = 22;
    localparam int unsigned BEATS_DEF  = 3;
    localparam int unsigned GROUP_W    = 48;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned GADDR_W    = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/vga_fetch.sv
// Single-entry pixel-group cache between the display stage and a 16-bit memory port.
// A miss fetches BEATS words starting at group*3 and tags them with the group index.
module vga_fetch
    import vga_pkg::*;
#(
    parameter int unsigned MEM_AW = MEM_AW_DEF,
    parameter int unsigned BEATS  = BEATS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vga_sel,
    input  logic [GADDR_W-1:0]   vga_addr,
    output logic [GROUP_W-1:0]   vga_data,
    output logic                 vga_valid,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [MEM_AW-1:0]    mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_W-1:0]    mem_rdata
);

    localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LAST   = BEATS - 1;
    localparam int unsigned BASE_W = GADDR_W + 2;

    fetch_state_e         state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [GADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
    logic [GADDR_W-1:0]   tag_q, tag_d;
    logic                 tag_valid_q, tag_valid_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [GROUP_W-1:0]   data_q, data_d;
    logic [BASE_W-1:0]    base;
    logic                 in_fetch;

    // Group index times three, widened so the top group does not wrap.
    assign base     = ({2'b00, fetch_addr_q} << 1) + {2'b00, fetch_addr_q};
    assign in_fetch = (state_q == ST_FETCH);

    assign mem_req   = in_fetch;
    assign mem_addr  = in_fetch ? (MEM_AW'(base) + MEM_AW'(beat_q)) : '0;
    assign vga_valid = vga_sel && tag_valid_q && (tag_q == vga_addr);
    assign vga_data  = data_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        fetch_addr_d = fetch_addr_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    tag_valid_d = 1'b0;
                end
                if (vga_sel && !vga_valid) begin
                    state_d      = ST_FETCH;
                    fetch_addr_d = vga_addr;
                    beat_d       = '0;
                    tag_valid_d  = 1'b0;
                    flush_pend_d = 1'b0;
                end
            end

            ST_FETCH: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    // Beat k lands in the k-th 16-bit lane counted from the MSB.
                    for (int unsigned k = 0; k < BEATS; k++) begin
                        if (beat_q == BW'(k)) begin
                            data_d[GROUP_W-1-WORD_W*k -: WORD_W] = mem_rdata;
                        end
                    end
                    if (beat_q == BW'(LAST)) begin
                        state_d = ST_FILL;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end

            ST_FILL: begin
                // A flush seen during the fetch or right now leaves the group untrusted.
                tag_d        = fetch_addr_q;
                tag_valid_d  = !(flush_pend_q || flush);
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            fetch_addr_q <= '0;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            fetch_addr_q <= fetch_addr_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
        end
    end

endmodule

// File: tb/tb_vga_fetch.sv
// Directed bench for vga_fetch with a small configurable-latency memory responder.
module tb_vga_fetch;

    logic        clk;
    logic        rst;
    logic        vga_sel;
    logic [19:0] vga_addr;
    logic [47:0] vga_data;
    logic        vga_valid;
    logic        flush;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int          wait_cfg = 0;
    int          wcnt     = 0;
    int          ack_idx  = 0;
    logic        force_ack = 1'b0;
    logic [21:0] held_addr = '0;
    logic [15:0] beat_data [3];
    logic [21:0] acked [$];

    vga_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .vga_sel   (vga_sel),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model: decides ack at the falling edge so the DUT sees it on the next rising edge.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt > 0) begin
                check("addr_hold", 64'(mem_addr), 64'(held_addr));
            end
            if (wcnt >= wait_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = beat_data[ack_idx % 3];
                acked.push_back(mem_addr);
                ack_idx++;
                wcnt = 0;
            end else begin
                if (wcnt == 0) held_addr = mem_addr;
                mem_ack   = 1'b0;
                mem_rdata = 16'h0;
                wcnt++;
            end
        end else begin
            mem_ack   = force_ack;
            mem_rdata = force_ack ? 16'hDEAD : 16'h0;
            wcnt      = 0;
            ack_idx   = 0;
        end
    end

    task automatic wait_valid(input string tag, input int budget, output int cycles);
        cycles = 0;
        #1;
        while (!vga_valid && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, "_valid"}, 64'(vga_valid), 64'd1);
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        int c;
        c = 0;
        while (acked.size() < n && c < budget) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (acked.size() < n) check({tag, "_ack_timeout"}, 64'(acked.size()), 64'(n));
    endtask

    task automatic check_addrs(input string tag, input logic [21:0] b0, input logic [21:0] b1,
                               input int n);
        check({tag, "_nbeats"}, 64'(acked.size()), 64'(n));
        for (int i = 0; i < n && i < acked.size(); i++) begin
            check({tag, "_addr"}, 64'(acked[i]), 64'((i < 3) ? b0 + 22'(i) : b1 + 22'(i - 3)));
        end
    endtask

    initial begin
        int lat;
        rst = 1'b0; vga_sel = 1'b1; vga_addr = 20'h0; flush = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0;
        beat_data[0] = 16'hAAAA; beat_data[1] = 16'hBBBB; beat_data[2] = 16'hCCCC;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_vga_valid", 64'(vga_valid), 64'd0);
        check("rst_vga_data", 64'(vga_data), 64'd0);
        vga_sel = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_mem_req", 64'(mem_req), 64'd0);

        // Zero-wait miss on group 0x10
        acked.delete();
        vga_sel = 1'b1; vga_addr = 20'h00010;
        wait_valid("zw", 20, lat);
        check("zw_latency", 64'(lat), 64'd5);
        check_addrs("zw", 22'h30, 22'h0, 3);
        check("zw_data", 64'(vga_data), 64'h0000_AAAA_BBBB_CCCC);

        // Two wait states per beat on group 0x20
        @(posedge clk); #1;
        acked.delete();
        wait_cfg = 2;
        beat_data[0] = 16'h1111; beat_data[1] = 16'h2222; beat_data[2] = 16'h3333;
        vga_addr = 20'h00020;
        wait_valid("ws", 30, lat);
        check("ws_latency", 64'(lat), 64'd11);
        check_addrs("ws", 22'h60, 22'h0, 3);
        check("ws_data", 64'(vga_data), 64'h0000_1111_2222_3333);
        wait_cfg = 0;

        // Address moves from 0x5 to 0x6 after beat 0: first fetch completes, then refetch
        @(posedge clk); #1;
        acked.delete();
        beat_data[0] = 16'h0505; beat_data[1] = 16'h5050; beat_data[2] = 16'h5A5A;
        vga_addr = 20'h00005;
        wait_acks("chg", 1, 10);
        vga_addr = 20'h00006;
        wait_valid("chg", 30, lat);
        check_addrs("chg", 22'h0F, 22'h12, 6);
        check("chg_data", 64'(vga_data), 64'h0000_0505_5050_5A5A);

        // Flush during fetch of 0x7: fill stays invalid and refetch follows immediately
        @(posedge clk); #1;
        acked.delete();
        beat_data[0] = 16'h7001; beat_data[1] = 16'h7002; beat_data[2] = 16'h7003;
        vga_addr = 20'h00007;
        wait_acks("fl", 1, 10);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_valid("fl", 30, lat);
        check_addrs("fl", 22'h15, 22'h15, 6);
        check("fl_data", 64'(vga_data), 64'h0000_7001_7002_7003);

        // Flush while hitting in IDLE drops vga_valid on the next cycle
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("fli_valid", 64'(vga_valid), 64'd0);
        vga_sel = 1'b0;
        check("fli_data", 64'(vga_data), 64'h0000_7001_7002_7003);

        // Stray ack while no request is outstanding
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        check("stray_mem_req", 64'(mem_req), 64'd0);
        check("stray_data", 64'(vga_data), 64'h0000_7001_7002_7003);

        // Top group index must not wrap the word address
        @(posedge clk); #1;
        acked.delete();
        beat_data[0] = 16'hF00D; beat_data[1] = 16'hBEEF; beat_data[2] = 16'hCAFE;
        vga_sel = 1'b1; vga_addr = 20'hFFFFF;
        wait_valid("max", 20, lat);
        check("max_latency", 64'(lat), 64'd5);
        check_addrs("max", 22'h2FFFFD, 22'h0, 3);
        check("max_data", 64'(vga_data), 64'h0000_F00D_BEEF_CAFE);

        // Reset after beat 1 abandons the fetch; after release it restarts from beat 0
        @(posedge clk); #1;
        acked.delete();
        beat_data[0] = 16'h1234; beat_data[1] = 16'h5678; beat_data[2] = 16'h9ABC;
        vga_addr = 20'h00040;
        wait_acks("rm", 2, 10);
        rst = 1'b0;
        #1;
        check("rm_mem_req", 64'(mem_req), 64'd0);
        check("rm_mem_addr", 64'(mem_addr), 64'd0);
        check("rm_vga_valid", 64'(vga_valid), 64'd0);
        check("rm_vga_data", 64'(vga_data), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        acked.delete();
        rst = 1'b1;
        wait_valid("rm", 20, lat);
        check("rm_latency", 64'(lat), 64'd5);
        check_addrs("rm", 22'hC0, 22'h0, 3);
        check("rm_data", 64'(vga_data), 64'h0000_1234_5678_9ABC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_fetch.md
VGA_FETCH -- requirements
Module: vga_fetch

Interface
REQ-001 Parameter MEM_AW, default 22, memory word-address width (16-bit words).
REQ-002 Parameter BEATS, default 3, number of 16-bit memory beats per 48-bit pixel group.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 vga_sel  input  1  level request from display stage for group at vga_addr.
REQ-006 vga_addr  input  20  pixel-group index (one group = 48 bits = 4 x 12-bit pixels).
REQ-007 vga_data  output  48  fetched group data.
REQ-008 vga_valid  output  1  vga_data corresponds to current vga_addr.
REQ-009 flush  input  1  one-cycle strobe; invalidates held group (frame buffer rewritten).
REQ-010 mem_req  output  1  memory read request.
REQ-011 mem_addr  output  MEM_AW  16-bit word address of current beat.
REQ-012 mem_ack  input  1  beat accepted; mem_rdata valid in same cycle.
REQ-013 mem_rdata  input  16  read data.

Function
REQ-014 Block SHALL hold one group: data register, tag register (20 b), tag_valid bit.
REQ-015 vga_valid SHALL be combinational: vga_sel & tag_valid & (tag == vga_addr).
REQ-016 vga_data SHALL drive the data register at all times.
REQ-017 FSM states SHALL be IDLE, FETCH (beat counter 0..BEATS-1), FILL.
REQ-018 IDLE -> FETCH when vga_sel high and vga_valid low; capture vga_addr as fetch_addr, beat=0.
REQ-019 Base word address SHALL be fetch_addr*3, computed as (fetch_addr<<1)+fetch_addr zero-extended to MEM_AW bits, no truncation.
REQ-020 In FETCH, mem_req SHALL be high and mem_addr = base + beat; both stable until mem_ack.
REQ-021 On mem_ack, beat k SHALL write mem_rdata into data[47-16k -: 16]; beat increments next cycle.
REQ-022 mem_ack on beat BEATS-1 SHALL move FSM to FILL; mem_req low in FILL and IDLE.
REQ-023 FILL SHALL last one cycle: tag <= fetch_addr, tag_valid <= !flush_pending, then IDLE.
REQ-024 vga_data SHALL not be considered valid during FETCH (tag_valid cleared on FETCH entry).
REQ-025 vga_addr change mid-fetch SHALL not abort; fetch completes, then REQ-018 re-evaluates (new fetch next IDLE cycle).
REQ-026 vga_sel dropping mid-fetch SHALL not abort the fetch.
REQ-027 flush in IDLE/FILL SHALL clear tag_valid next cycle; flush in FETCH SHALL set flush_pending, cleared at FILL.
REQ-028 flush and FILL in same cycle SHALL leave tag_valid = 0.
REQ-029 mem_ack while mem_req low SHALL be ignored.
REQ-030 Miss-to-valid latency with zero-wait memory (ack same cycle as req): 1 (IDLE) + 3 (FETCH) + 1 (FILL) = 5 cycles.

Reset
REQ-031 rst low SHALL asynchronously force: state IDLE, beat 0, tag_valid 0, flush_pending 0, tag 0, data 0, fetch_addr 0.
REQ-032 During and after reset: mem_req 0, mem_addr 0, vga_valid 0, vga_data 0.
REQ-033 Reset mid-fetch SHALL abandon beats; first cycle after release is IDLE.

Structure
REQ-034 Package vga_pkg SHALL hold FSM state typedef, MEM_AW and BEATS defaults, group width 48.
REQ-035 Address-times-3 logic SHALL be inline; no sub-module required.

Verification
REQ-036 Miss, zero-wait: vga_sel=1, vga_addr=0x00010, ack every cycle, rdata 0xAAAA,0xBBBB,0xCCCC -> mem_addr 0x30,0x31,0x32; vga_data 0xAAAABBBBCCCC; vga_valid high 5 cycles after request.
REQ-037 Wait states: ack delayed 2 cycles per beat -> mem_addr/mem_req held stable; vga_valid 11 cycles after request.
REQ-038 Address change mid-fetch: vga_addr 0x5 -> 0x6 after beat 0 -> fetch 0x5 completes (tag 0x5), vga_valid stays 0, new fetch base 0x12.
REQ-039 Flush during FETCH for 0x7 -> FILL leaves tag_valid 0, immediate refetch at base 0x15; flush in IDLE with hit -> vga_valid low next cycle.
REQ-040 Max address: vga_addr 0xFFFFF -> mem_addr 0x2FFFFD..0x2FFFFF, no wrap.
REQ-041 rst asserted after beat 1 -> mem_req 0 immediately, vga_valid 0; post-release request refetches from beat 0.
